// File: rtl/operand_forward_unit.sv
// EX operand select/capture from regfile, ALU-stage or WB-stage results,
// with load-use stall control and a saturating stall counter.
module operand_forward_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  fwd_rs1_mem,
  input  logic                  fwd_rs2_mem,
  input  logic                  fwd_rs1_wb,
  input  logic                  fwd_rs2_wb,
  input  logic [DATA_WIDTH-1:0] alu_stage_result,
  input  logic [DATA_WIDTH-1:0] wb_stage_result,
  input  logic                  alu_stage_is_load,
  input  logic [ADDR_WIDTH-1:0] alu_stage_dest,
  input  logic                  dmem_busy,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [DATA_WIDTH-1:0] ex_operand1,
  output logic [DATA_WIDTH-1:0] ex_operand2,
  output logic [CNT_WIDTH-1:0]  stall_cycles
);

  localparam logic [0:0] RUN       = 1'b0;
  localparam logic [0:0] LOAD_WAIT = 1'b1;

  logic [0:0]            state;
  logic                  load_use;
  logic [DATA_WIDTH-1:0] next_operand1;
  logic [DATA_WIDTH-1:0] next_operand2;

  // x0 is hardwired zero; ALU-stage data is newer than WB-stage data.
  function automatic logic [DATA_WIDTH-1:0] select_operand(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic                  mem_en,
    input logic                  wb_en,
    input logic [DATA_WIDTH-1:0] reg_value,
    input logic [DATA_WIDTH-1:0] mem_value,
    input logic [DATA_WIDTH-1:0] wb_value
  );
    if (addr == '0)  return '0;
    else if (mem_en) return mem_value;
    else if (wb_en)  return wb_value;
    else             return reg_value;
  endfunction

  always_comb begin
    load_use = id_valid && alu_stage_is_load && (alu_stage_dest != '0) &&
               ((alu_stage_dest == rs1_addr) || (alu_stage_dest == rs2_addr));
    if (reset)               stall = 1'b0;
    else if (state == RUN)   stall = load_use;
    else                     stall = dmem_busy;
    next_operand1 = select_operand(rs1_addr, fwd_rs1_mem, fwd_rs1_wb,
                                   rs1_data, alu_stage_result, wb_stage_result);
    next_operand2 = select_operand(rs2_addr, fwd_rs2_mem, fwd_rs2_wb,
                                   rs2_data, alu_stage_result, wb_stage_result);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      ex_valid     <= 1'b0;
      ex_operand1  <= '0;
      ex_operand2  <= '0;
      stall_cycles <= '0;
    end else begin
      case (state)
        RUN:       if (load_use)   state <= LOAD_WAIT;
        LOAD_WAIT: if (!dmem_busy) state <= RUN;
        default:                   state <= RUN;
      endcase

      if (stall) begin
        ex_valid <= 1'b0;
      end else begin
        ex_valid    <= id_valid;
        ex_operand1 <= next_operand1;
        ex_operand2 <= next_operand2;
      end

      if (stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_operand_forward_unit.sv
// Self-checking bench: directed vector table, hand-written stall/reset
// sequences and randomized cycles against a behavioural model.
module tb_operand_forward_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  rs1_addr, rs2_addr, alu_stage_dest;
  logic [31:0] rs1_data, rs2_data, alu_stage_result, wb_stage_result;
  logic        fwd_rs1_mem, fwd_rs2_mem, fwd_rs1_wb, fwd_rs2_wb;
  logic        alu_stage_is_load, dmem_busy;

  logic        stall, ex_valid;
  logic [31:0] ex_operand1, ex_operand2;
  logic [15:0] stall_cycles;

  logic        stall_s, ex_valid_s;
  logic [31:0] ex_operand1_s, ex_operand2_s;
  logic [1:0]  stall_cycles_s;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  bit          m_wait;
  bit          m_valid;
  logic [31:0] m_op1, m_op2;
  int          m_cnt;
  bit          last_stall;

  always #5 clk = ~clk;

  operand_forward_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fwd_rs1_mem(fwd_rs1_mem), .fwd_rs2_mem(fwd_rs2_mem),
    .fwd_rs1_wb(fwd_rs1_wb), .fwd_rs2_wb(fwd_rs2_wb),
    .alu_stage_result(alu_stage_result), .wb_stage_result(wb_stage_result),
    .alu_stage_is_load(alu_stage_is_load), .alu_stage_dest(alu_stage_dest),
    .dmem_busy(dmem_busy), .stall(stall), .ex_valid(ex_valid),
    .ex_operand1(ex_operand1), .ex_operand2(ex_operand2),
    .stall_cycles(stall_cycles)
  );

  // Narrow counter instance exercises saturation within a short run.
  operand_forward_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fwd_rs1_mem(fwd_rs1_mem), .fwd_rs2_mem(fwd_rs2_mem),
    .fwd_rs1_wb(fwd_rs1_wb), .fwd_rs2_wb(fwd_rs2_wb),
    .alu_stage_result(alu_stage_result), .wb_stage_result(wb_stage_result),
    .alu_stage_is_load(alu_stage_is_load), .alu_stage_dest(alu_stage_dest),
    .dmem_busy(dmem_busy), .stall(stall_s), .ex_valid(ex_valid_s),
    .ex_operand1(ex_operand1_s), .ex_operand2(ex_operand2_s),
    .stall_cycles(stall_cycles_s)
  );

  typedef struct {
    bit          id_valid;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    bit          fm1, fm2, fw1, fw2;
    logic [31:0] alu_res, wb_res;
    bit          is_load;
    logic [4:0]  dest;
    bit          exp_stall, exp_valid;
    logic [31:0] exp_op1, exp_op2;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_pick(input logic [4:0] a, input bit m, input bit w,
                                           input logic [31:0] r, input logic [31:0] mv,
                                           input logic [31:0] wv);
    if (a == 0) return 32'h0;
    if (m) return mv;
    if (w) return wv;
    return r;
  endfunction

  task automatic clear_inputs();
    id_valid = 0; rs1_addr = 0; rs2_addr = 0; rs1_data = 0; rs2_data = 0;
    fwd_rs1_mem = 0; fwd_rs2_mem = 0; fwd_rs1_wb = 0; fwd_rs2_wb = 0;
    alu_stage_result = 0; wb_stage_result = 0; alu_stage_is_load = 0;
    alu_stage_dest = 0; dmem_busy = 0;
  endtask

  // One clock: check stall, advance the model, check registered outputs.
  // A load-use stall is pending exactly while the previous cycle stalled.
  task automatic cycle();
    bit lu, es;
    #2;
    lu = id_valid && alu_stage_is_load && alu_stage_dest != 0 &&
         (alu_stage_dest == rs1_addr || alu_stage_dest == rs2_addr);
    es = reset ? 1'b0 : (m_wait ? dmem_busy : lu);
    chk("stall", {31'b0, stall}, {31'b0, es});
    chk("stall_sat_inst", {31'b0, stall_s}, {31'b0, es});
    if (reset) begin
      m_wait = 0; m_valid = 0; m_op1 = 0; m_op2 = 0; m_cnt = 0;
    end else begin
      if (es) begin
        m_valid = 0;
        m_cnt++;
      end else begin
        m_valid = id_valid;
        m_op1 = ref_pick(rs1_addr, fwd_rs1_mem, fwd_rs1_wb, rs1_data, alu_stage_result, wb_stage_result);
        m_op2 = ref_pick(rs2_addr, fwd_rs2_mem, fwd_rs2_wb, rs2_data, alu_stage_result, wb_stage_result);
      end
      m_wait = es;
    end
    last_stall = es;
    @(posedge clk);
    #1;
    chk("ex_valid", {31'b0, ex_valid}, {31'b0, m_valid});
    chk("ex_operand1", ex_operand1, m_op1);
    chk("ex_operand2", ex_operand2, m_op2);
    chk("stall_cycles", {16'b0, stall_cycles}, (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
    chk("stall_cycles_sat", {30'b0, stall_cycles_s}, (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
  endtask

  vec_t vecs[5];
  int   stall_hi;
  logic [31:0] held1, held2;

  initial begin
    // directed single-cycle vectors, applied from RUN with no pending hazard
    vecs[0] = '{1, 5'd3, 5'd4, 32'h11, 32'h22, 0, 0, 0, 0, 32'h0, 32'h0, 0, 5'd0,
                0, 1, 32'h11, 32'h22};
    vecs[1] = '{1, 5'd3, 5'd0, 32'h10, 32'h55, 1, 1, 1, 0, 32'hAAAA, 32'hBBBB, 0, 5'd0,
                0, 1, 32'hAAAA, 32'h0};
    vecs[2] = '{1, 5'd7, 5'd8, 32'h77, 32'h88, 0, 0, 0, 1, 32'hAAAA, 32'hBBBB, 0, 5'd0,
                0, 1, 32'h77, 32'hBBBB};
    vecs[3] = '{1, 5'd0, 5'd2, 32'h99, 32'h33, 0, 0, 0, 0, 32'h0, 32'h0, 1, 5'd0,
                0, 1, 32'h0, 32'h33};
    vecs[4] = '{0, 5'd5, 5'd6, 32'h44, 32'h66, 0, 0, 0, 0, 32'h0, 32'h0, 1, 5'd5,
                0, 0, 32'h44, 32'h66};

    clear_inputs();
    reset = 1;
    @(posedge clk); #1;
    cycle();
    chk("reset_ex_valid", {31'b0, ex_valid}, 32'h0);
    chk("reset_stall_cycles", {16'b0, stall_cycles}, 32'h0);
    reset = 0;

    for (int i = 0; i < 5; i++) begin
      id_valid = vecs[i].id_valid; rs1_addr = vecs[i].rs1_addr; rs2_addr = vecs[i].rs2_addr;
      rs1_data = vecs[i].rs1_data; rs2_data = vecs[i].rs2_data;
      fwd_rs1_mem = vecs[i].fm1; fwd_rs2_mem = vecs[i].fm2;
      fwd_rs1_wb = vecs[i].fw1; fwd_rs2_wb = vecs[i].fw2;
      alu_stage_result = vecs[i].alu_res; wb_stage_result = vecs[i].wb_res;
      alu_stage_is_load = vecs[i].is_load; alu_stage_dest = vecs[i].dest;
      dmem_busy = 0;
      cycle();
      chk($sformatf("vec%0d_stall", i), {31'b0, last_stall}, {31'b0, vecs[i].exp_stall});
      chk($sformatf("vec%0d_valid", i), {31'b0, ex_valid}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_op1", i), ex_operand1, vecs[i].exp_op1);
      chk($sformatf("vec%0d_op2", i), ex_operand2, vecs[i].exp_op2);
    end

    // single load-use bubble, then WB forwarding of the load data
    clear_inputs();
    reset = 1; cycle(); reset = 0;
    id_valid = 1; rs1_addr = 1; rs2_addr = 5; rs1_data = 32'h1; rs2_data = 32'hDEAD;
    alu_stage_is_load = 1; alu_stage_dest = 5;
    cycle();
    chk("lu_stall", {31'b0, last_stall}, 32'h1);
    chk("lu_bubble", {31'b0, ex_valid}, 32'h0);
    alu_stage_is_load = 0; alu_stage_dest = 0; fwd_rs2_wb = 1; wb_stage_result = 32'h1234;
    cycle();
    chk("lu_release_stall", {31'b0, last_stall}, 32'h0);
    chk("lu_fwd_op2", ex_operand2, 32'h1234);
    chk("lu_valid", {31'b0, ex_valid}, 32'h1);
    chk("lu_count", {16'b0, stall_cycles}, 32'h1);

    // load-use with three busy cycles; both sources match the load dest
    clear_inputs();
    reset = 1; cycle(); reset = 0;
    id_valid = 1; rs1_addr = 6; rs2_addr = 6; rs1_data = 32'hC1; rs2_data = 32'hC2;
    cycle();
    held1 = ex_operand1; held2 = ex_operand2;
    alu_stage_is_load = 1; alu_stage_dest = 6; rs1_data = 32'hE1; rs2_data = 32'hE2;
    stall_hi = 0;
    for (int i = 0; i < 4; i++) begin
      dmem_busy = (i != 0);
      cycle();
      if (last_stall) stall_hi++;
      chk("busy_bubble", {31'b0, ex_valid}, 32'h0);
      chk("busy_hold_op1", ex_operand1, held1);
      chk("busy_hold_op2", ex_operand2, held2);
      alu_stage_is_load = 0;
    end
    dmem_busy = 0; fwd_rs1_wb = 1; wb_stage_result = 32'h5A5A;
    cycle();
    chk("busy_stall_total", 32'(stall_hi), 32'd4);
    chk("busy_count", {16'b0, stall_cycles}, 32'd4);
    chk("busy_sat_count", {30'b0, stall_cycles_s}, 32'd3);
    chk("busy_release_op1", ex_operand1, 32'h5A5A);

    // reset while waiting on a busy load
    id_valid = 1; rs1_addr = 9; alu_stage_is_load = 1; alu_stage_dest = 9; fwd_rs1_wb = 0;
    cycle();
    dmem_busy = 1; alu_stage_is_load = 0;
    cycle();
    reset = 1;
    cycle();
    chk("rst_wait_valid", {31'b0, ex_valid}, 32'h0);
    chk("rst_wait_op1", ex_operand1, 32'h0);
    chk("rst_wait_count", {16'b0, stall_cycles}, 32'h0);
    reset = 0; dmem_busy = 1;
    cycle();
    chk("rst_wait_stall_after", {31'b0, last_stall}, 32'h0);

    // randomized cycles against the model
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      id_valid = ($urandom_range(0, 3) != 0);
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 7));
      rs1_data = $urandom; rs2_data = $urandom;
      fwd_rs1_mem = $urandom_range(0, 1); fwd_rs2_mem = $urandom_range(0, 1);
      fwd_rs1_wb = $urandom_range(0, 1);  fwd_rs2_wb = $urandom_range(0, 1);
      alu_stage_result = $urandom; wb_stage_result = $urandom;
      alu_stage_is_load = ($urandom_range(0, 2) == 0);
      alu_stage_dest = 5'($urandom_range(0, 7));
      dmem_busy = ($urandom_range(0, 1) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_forward_unit.md
Name: operand_forward_unit

Overview:
- Consumer end of the forwarding-enable interface. It takes the four forward-enable signals from the ALU hazard unit, selects the EX-stage operands from the register file, the ALU-stage result or the WB-stage result, and registers them into the ID/EX operand latches.
- It also owns load-use stall control: it detects a load-use hazard, holds PC and IF/ID, and inserts EX bubbles until load data can be forwarded from WB.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- ADDR_WIDTH, 5, register address width.
- CNT_WIDTH, 16, stall performance counter width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- id_valid  input  1  ID stage holds a real instruction.
- rs1_addr  input  ADDR_WIDTH  ID-stage rs1 address.
- rs2_addr  input  ADDR_WIDTH  ID-stage rs2 address.
- rs1_data  input  DATA_WIDTH  register file read data, port 1.
- rs2_data  input  DATA_WIDTH  register file read data, port 2.
- fwd_rs1_mem  input  1  forward ALU-stage result to rs1.
- fwd_rs2_mem  input  1  forward ALU-stage result to rs2.
- fwd_rs1_wb  input  1  forward WB-stage result to rs1.
- fwd_rs2_wb  input  1  forward WB-stage result to rs2.
- alu_stage_result  input  DATA_WIDTH  result of the instruction one ahead.
- wb_stage_result  input  DATA_WIDTH  result of the instruction two ahead.
- alu_stage_is_load  input  1  instruction in ALU stage is a load.
- alu_stage_dest  input  ADDR_WIDTH  destination of that instruction.
- dmem_busy  input  1  data memory has not completed the load.
- stall  output  1  combinational; hold PC and IF/ID.
- ex_valid  output  1  registered; EX holds a real instruction.
- ex_operand1  output  DATA_WIDTH  registered EX operand 1.
- ex_operand2  output  DATA_WIDTH  registered EX operand 2.
- stall_cycles  output  CNT_WIDTH  saturating count of stalled cycles.

Behaviour:
- Reset (synchronous, at posedge with reset=1):
  - state=RUN; ex_valid=0; ex_operand1=0; ex_operand2=0; stall_cycles=0.
  - stall is 0 while reset=1.
- load_use is asserted when all of the following hold:
  - id_valid=1;
  - alu_stage_is_load=1;
  - alu_stage_dest!=0;
  - alu_stage_dest==rs1_addr or alu_stage_dest==rs2_addr.
- State machine, states RUN and LOAD_WAIT:
  - RUN: stall=load_use. If load_use=1, go to LOAD_WAIT at the next edge; otherwise stay in RUN.
  - LOAD_WAIT: stall=dmem_busy. If dmem_busy=1, stay in LOAD_WAIT; otherwise return to RUN at the next edge and capture operands in that cycle.
  - At least one bubble is always inserted per load-use hazard; each dmem_busy cycle adds one more.
- Operand capture at each posedge, when not in reset:
  - stall=1: ex_valid<=0 (bubble); ex_operand1/2 hold their values.
  - stall=0: ex_valid<=id_valid, and each operand is loaded with the first matching source in this priority order:
    1. rsN_addr==0 → 0. x0 is never forwarded, whatever the enables say.
    2. fwd_rsN_mem=1 → alu_stage_result. Newest data wins when both enables are set.
    3. fwd_rsN_wb=1 → wb_stage_result.
    4. otherwise → rsN_data.
  - Operands are captured even when id_valid=0, but ex_valid=0 marks them don't-care.
- Forward enables and results are trusted as presented in the capture cycle; no internal address compare is made for forwarding.
- stall_cycles:
  - Increments by 1 on every posedge where stall=1 and reset=0.
  - Saturates at all-ones with no wrap.
  - Cleared only by reset.
- Latency: 1 cycle from ID inputs to the registered EX outputs.
- Reset mid-stall: returns to RUN, drops stall the same cycle, and discards the pending bubble.
- load_use with both rs1 and rs2 matching still produces a single stall sequence.

Test Plan:
1. No hazard: rs1_addr=3, rs1_data=0x11, all enables 0, id_valid=1 → next cycle ex_operand1=0x11, ex_valid=1, stall=0.
2. Priority:
   - fwd_rs1_mem=1, fwd_rs1_wb=1, alu_stage_result=0xAAAA, wb_stage_result=0xBBBB → ex_operand1=0xAAAA.
   - rs2_addr=0 with fwd_rs2_mem=1 → ex_operand2=0.
3. Load-use: alu_stage_is_load=1, alu_stage_dest=5, rs2_addr=5, dmem_busy=0.
   - stall=1 for exactly 1 cycle and ex_valid=0 for one cycle.
   - Next cycle, with fwd_rs2_wb=1 and wb_stage_result=0x1234 → ex_operand2=0x1234, ex_valid=1.
   - stall_cycles=1.
4. Load-use with dmem_busy held 3 cycles in LOAD_WAIT → stall high 4 cycles total, 4 bubbles, stall_cycles=4, operands held throughout.
5. Load with alu_stage_dest=0 matching rs1_addr=0 → no stall; ex_operand1=0.
6. Reset asserted in LOAD_WAIT → after the edge, state=RUN, stall=0, ex_valid=0, operands=0, stall_cycles=0.
   - Separately, preload the counter to 0xFFFE and stall 3 cycles → counter stays at 0xFFFF.
